pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and clear controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB stage registers. It resolves three hazard classes in fixed priority: data-memory wait (full freeze), load-use (one bubble), and taken branch (IF flush). It also keeps saturating stall and flush performance counters and raises a sticky timeout error on a hung memory access.

Parameters:
CNT_W, 32, width of the stall and flush performance counters
MEM_TIMEOUT, 64, maximum number of MEM_WAIT cycles before err_o sets; must be >=1

Ports:
clk_i  in  1  clock; the block has one clock, all state updates on its rising edge
rst_i  in  1  reset; reset is synchronous and active-low
id_rs_i  in  5  RS address of the instruction in ID
id_rt_i  in  5  RT address of the instruction in ID
id_use_rs_i  in  1  ID instruction reads RS
id_use_rt_i  in  1  ID instruction reads RT
ex_memread_i  in  1  MemRead output of ID_EX (a load is in EX)
ex_rt_i  in  5  RTaddr output of ID_EX (load destination)
branch_taken_i  in  1  branch resolved taken in ID this cycle
mem_req_i  in  1  MEM stage has a data-memory access outstanding
mem_ack_i  in  1  data memory completes the access this cycle
pc_we_o  out  1  PC write enable
if_id_we_o  out  1  IF_ID write enable
if_id_flush_o  out  1  IF_ID loads a NOP
id_ex_bubble_o  out  1  ID_EX loads zero control bits (ALUOp, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg)
ex_mem_we_o  out  1  EX_MEM write enable
mem_wb_we_o  out  1  MEM_WB write enable
stall_cnt_o  out  CNT_W  cycles with pc_we_o=0 since reset, saturating
flush_cnt_o  out  CNT_W  IF_ID flush events since reset, saturating
err_o  out  1  sticky memory timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, HUNG. Encoding 2 bits.
- Reset (rst_i=0 at a clock edge): state=RUN, both counters=0, wait_cnt=0, err_o=0.
- While rst_i=0, the combinational outputs are forced to: pc_we_o=0, if_id_we_o=0, ex_mem_we_o=0, mem_wb_we_o=0, if_id_flush_o=1, id_ex_bubble_o=1. The pipeline fills with bubbles. This holds for reset asserted mid-operation, including in MEM_WAIT.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. Counters and err_o are registered.
- mem_hold = mem_req_i & ~mem_ack_i.
- load_use = ex_memread_i & (ex_rt_i!=0) & ((id_use_rs_i & id_rs_i==ex_rt_i) | (id_use_rt_i & id_rt_i==ex_rt_i)).
- RUN, priority 1 (mem_hold): all five enables 0, flush=0, bubble=0 (full freeze). Next state MEM_WAIT, wait_cnt=1.
- RUN, priority 2 (load_use): pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1, ex_mem_we_o=1, mem_wb_we_o=1. A branch_taken_i in the same cycle is ignored; it re-resolves after the stall.
- RUN, priority 3 (branch_taken_i): all enables 1, if_id_flush_o=1.
- RUN, otherwise: all enables 1, flush=0, bubble=0.
- MEM_WAIT, mem_ack_i=0: full freeze, wait_cnt++. When wait_cnt reaches MEM_TIMEOUT, go to HUNG and set err_o.
- MEM_WAIT, mem_ack_i=1: outputs are evaluated exactly as in RUN (the freeze releases in the ack cycle). Next state RUN.
- mem_req_i and mem_ack_i in the same RUN cycle: no stall.
- HUNG: full freeze permanently; only reset exits.
- stall_cnt_o increments on every non-reset cycle with pc_we_o=0.
- flush_cnt_o increments on every non-reset cycle with if_id_flush_o=1.
- Both counters saturate at all-ones.

Decomposition:
- Shared package pipe_pkg:
  - state enum (RUN, MEM_WAIT, HUNG)
  - REG_ZERO=5'd0
  - a ctrl_bundle struct {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we} with constants CTRL_RUN, CTRL_FREEZE, CTRL_RESET
- Sub-module sat_counter (parameter W; inputs inc, clear): instantiated twice.

Test Plan:
1. Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8, id_use_rs_i=1 for one cycle -> pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1, ex_mem_we_o=1 that cycle; stall_cnt_o=1 next cycle.
2. ex_rt_i=0 with matching id_rs_i=0 -> no stall. Separately, id_use_rt_i=0 with a matching RT -> no stall.
3. Branch: branch_taken_i=1 alone -> if_id_flush_o=1, all enables 1, flush_cnt_o +1. Same cycle as load_use -> flush=0, bubble=1, flush_cnt_o unchanged.
4. Memory wait: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack=1 -> 3 freeze cycles with all enables 0; ack cycle has enables 1; stall_cnt_o=3.
5. Timeout: MEM_TIMEOUT=4, ack held 0 -> err_o=1 after the 4th wait cycle; state stays frozen; rst_i=0 for one edge clears err_o and the counters.
6. Saturation: CNT_W=3 with 10 stall cycles -> stall_cnt_o holds 7. Reset in MEM_WAIT -> flush=1, bubble=1, all enables 0 during reset; state RUN afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose: shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HUNG     = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Stage-register controls, one bit per stage action.
   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_we;
      logic mem_wb_we;
   } ctrl_bundle_t;

   // Free-running pipeline: every stage advances.
   localparam ctrl_bundle_t CTRL_RUN = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1};
   // Every stage holds its contents.
   localparam ctrl_bundle_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                            id_ex_bubble: 1'b0, ex_mem_we: 1'b0, mem_wb_we: 1'b0};
   // Reset fills the front of the pipe with bubbles and holds everything else.
   localparam ctrl_bundle_t CTRL_RESET = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                           id_ex_bubble: 1'b1, ex_mem_we: 1'b0, mem_wb_we: 1'b0};
   // Load-use: hold PC and IF_ID, inject one bubble into EX, let the back end drain.
   localparam ctrl_bundle_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                              id_ex_bubble: 1'b1, ex_mem_we: 1'b1, mem_wb_we: 1'b1};
   // Taken branch: keep flowing but squash the wrong-path fetch in IF_ID.
   localparam ctrl_bundle_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                            id_ex_bubble: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1};

   // A load in EX whose destination is a live source of the ID instruction.
   // Register zero is hardwired, so a load to it never creates a dependency.
   function automatic logic is_load_use(input logic       ex_memread,
                                        input logic [4:0] ex_rt,
                                        input logic       use_rs,
                                        input logic [4:0] rs,
                                        input logic       use_rt,
                                        input logic [4:0] rt);
      return ex_memread && (ex_rt != REG_ZERO) &&
             ((use_rs && (rs == ex_rt)) || (use_rt && (rt == ex_rt)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Purpose: saturating event counter with synchronous clear.
// Latency: count visible one cycle after the inc pulse.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         inc_i,
   input  logic         clear_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline (mem wait > load-use > branch).
// Latency: controls combinational in the same cycle; counters and err_o one cycle later.
// Backpressure: a pending data-memory access freezes every stage until mem_ack_i.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_we_o,
   output logic             if_id_we_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             ex_mem_we_o,
   output logic             mem_wb_we_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   // Wide enough to hold MEM_TIMEOUT itself.
   localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;

   logic         mem_hold;
   logic         load_use;
   ctrl_bundle_t run_ctrl;
   ctrl_bundle_t ctrl;

   assign mem_hold = mem_req_i & ~mem_ack_i;
   assign load_use = is_load_use(ex_memread_i, ex_rt_i, id_use_rs_i, id_rs_i,
                                 id_use_rt_i, id_rt_i);

   // Hazard resolution as seen from a running pipeline. A branch coinciding
   // with a load-use stall is dropped; ID re-resolves it after the bubble.
   always_comb begin
      run_ctrl = CTRL_RUN;
      if (mem_hold) begin
         run_ctrl = CTRL_FREEZE;
      end else if (load_use) begin
         run_ctrl = CTRL_LOAD_USE;
      end else if (branch_taken_i) begin
         run_ctrl = CTRL_BRANCH;
      end
   end

   // State, wait counter and sticky error registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Next state: the cycle that raises the request counts as the first wait cycle.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            if (mem_hold) begin
               wait_d = WAIT_W'(1);
               if (MEM_TIMEOUT <= 1) begin
                  state_d = HUNG;
                  err_d   = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i) begin
               state_d = RUN;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
               if (wait_d >= WAIT_LIMIT) begin
                  state_d = HUNG;
                  err_d   = 1'b1;
               end
            end
         end
         HUNG: begin
            state_d = HUNG;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Stage controls: reset overrides everything; the ack cycle releases the freeze.
   always_comb begin
      ctrl = CTRL_FREEZE;
      if (!rst_i) begin
         ctrl = CTRL_RESET;
      end else begin
         unique case (state_q)
            RUN:      ctrl = run_ctrl;
            MEM_WAIT: ctrl = mem_ack_i ? run_ctrl : CTRL_FREEZE;
            HUNG:     ctrl = CTRL_FREEZE;
            default:  ctrl = CTRL_FREEZE;
         endcase
      end
   end

   assign pc_we_o        = ctrl.pc_we;
   assign if_id_we_o     = ctrl.if_id_we;
   assign if_id_flush_o  = ctrl.if_id_flush;
   assign id_ex_bubble_o = ctrl.id_ex_bubble;
   assign ex_mem_we_o    = ctrl.ex_mem_we;
   assign mem_wb_we_o    = ctrl.mem_wb_we;
   assign err_o          = err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .inc_i   (rst_i & ~ctrl.pc_we),
      .clear_i (~rst_i),
      .cnt_o   (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .inc_i   (rst_i & ctrl.if_id_flush),
      .clear_i (~rst_i),
      .cnt_o   (flush_cnt_o)
   );

endmodule
